commit_arbiter: RTL and testbench
=================================

COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of execute-unit commit sources (ALU, LSU, CSR, FPU order; index 0 = ALU).
REQ-002 SHALL have parameter NUM_THREADS, default 4, lanes per warp.
REQ-003 SHALL have parameters NW_BITS default 2, NR_BITS default 6, UUID_BITS default 44: warp-id, register-id and uuid widths.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk input 1 system clock; reset input 1 sync active-high reset.
REQ-005 in_valid input NUM_REQS; per-source commit valid.
REQ-006 in_ready output NUM_REQS; per-source accept.
REQ-007 in_uuid input NUM_REQS*UUID_BITS; in_wid input NUM_REQS*NW_BITS; in_tmask input NUM_REQS*NUM_THREADS.
REQ-008 in_PC input NUM_REQS*32; in_rd input NUM_REQS*NR_BITS; in_wb input NUM_REQS; in_eop input NUM_REQS.
REQ-009 in_data input NUM_REQS*NUM_THREADS*32; per-lane result.
REQ-010 out_valid, out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_eop, out_data: outputs, single-source widths, registered commit to writeback.
REQ-011 out_ready input 1; writeback accept.
REQ-012 perf_commits output 64; retired-instruction count.

Function
REQ-013 Transfer on source k SHALL occur when in_valid[k] && in_ready[k]; on output when out_valid && out_ready.
REQ-014 At most one in_ready bit SHALL be high per cycle; in_ready[k] = grant[k] && (~out_valid || out_ready).
REQ-015 Grant SHALL be round-robin: highest priority at pointer P, then P+1 ... mod NUM_REQS; lowest valid index at/after P wins.
REQ-016 After a source-k transfer with in_eop[k]=1, P SHALL become (k+1) mod NUM_REQS; P unchanged otherwise.
REQ-017 A source-k transfer with in_eop[k]=0 SHALL lock the grant to k until k transfers with in_eop=1; other sources get in_ready=0 while locked, even if k drops in_valid.
REQ-018 Accepted fields SHALL appear on out_* exactly 1 cycle after the input transfer, unmodified.
REQ-019 Output register SHALL hold contents stable while out_valid && ~out_ready.
REQ-020 Simultaneous output drain and new input transfer in one cycle SHALL replace the register with no bubble (full throughput, 1 commit/cycle).
REQ-021 out_valid SHALL drop the cycle after an output transfer with no concurrent input transfer.
REQ-022 No input valid: no grant, P and lock unchanged.
REQ-023 in_wb=0 commits SHALL pass through identically; arbiter SHALL not filter on wb.

Reset
REQ-024 On reset: out_valid=0, P=0, lock cleared, perf_commits=0; other out_* don't-care.
REQ-025 Reset mid-operation SHALL discard a held output entry and any lock; in_ready=0 during the reset cycle.

Configuration
REQ-026 Macro COMMIT_PERF_COUNTERS_EN: when defined, perf_commits SHALL increment by 1 on each output transfer with out_eop=1, wrapping at 2^64.
REQ-027 When COMMIT_PERF_COUNTERS_EN is undefined, perf_commits SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-028 Sources 0 and 2 valid same cycle after reset, eop=1, out_ready=1 -> source 0 out first (cycle 1), source 2 next (cycle 2), P=3.
REQ-029 All 4 sources continuously valid, eop=1, out_ready=1 -> grants 0,1,2,3,0,... one per cycle, out_valid high every cycle after first.
REQ-030 Source 1 sends 3 beats eop=0,0,1 while source 0 valid -> outputs 1,1,1 then 0; in_ready[0]=0 throughout lock.
REQ-031 out_ready=0 for 5 cycles with source 0 valid, data 0xDEADBEEF -> out_data stable 0xDEADBEEF, in_ready=0 all sources; one transfer on release.
REQ-032 reset asserted while out_valid=1 and lock active -> next cycle out_valid=0, P=0, lock clear, source 0 granted first.
REQ-033 With COMMIT_PERF_COUNTERS_EN, 10 eop=1 and 4 eop=0 output transfers -> perf_commits=10; without macro -> 0.

Source files
------------

// File: rtl/commit_arbiter.sv
// Commit arbiter: round-robin selection among execute-unit commit sources into a
// single registered writeback slot. A non-eop beat locks the grant to its source
// until that source sends its eop beat.
// Optional retired-instruction counter built only when COMMIT_PERF_COUNTERS_EN is defined.
module commit_arbiter #(
   parameter int unsigned NUM_REQS    = 4,
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned NW_BITS     = 2,
   parameter int unsigned NR_BITS     = 6,
   parameter int unsigned UUID_BITS   = 44
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [NUM_REQS-1:0]             in_valid_i,
   output logic [NUM_REQS-1:0]             in_ready_o,
   input  logic [NUM_REQS*UUID_BITS-1:0]   in_uuid_i,
   input  logic [NUM_REQS*NW_BITS-1:0]     in_wid_i,
   input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask_i,
   input  logic [NUM_REQS*32-1:0]          in_PC_i,
   input  logic [NUM_REQS*NR_BITS-1:0]     in_rd_i,
   input  logic [NUM_REQS-1:0]             in_wb_i,
   input  logic [NUM_REQS-1:0]             in_eop_i,
   input  logic [NUM_REQS*NUM_THREADS*32-1:0] in_data_i,
   output logic                            out_valid_o,
   output logic [UUID_BITS-1:0]            out_uuid_o,
   output logic [NW_BITS-1:0]              out_wid_o,
   output logic [NUM_THREADS-1:0]          out_tmask_o,
   output logic [31:0]                     out_PC_o,
   output logic [NR_BITS-1:0]              out_rd_o,
   output logic                            out_wb_o,
   output logic                            out_eop_o,
   output logic [NUM_THREADS*32-1:0]       out_data_o,
   input  logic                            out_ready_i,
   output logic [63:0]                     perf_commits_o
);

   localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

   logic [IDX_W-1:0] ptr_q, lock_idx_q;
   logic             lock_q;
   logic             out_valid_q;
   logic [UUID_BITS-1:0]      out_uuid_q;
   logic [NW_BITS-1:0]        out_wid_q;
   logic [NUM_THREADS-1:0]    out_tmask_q;
   logic [31:0]               out_pc_q;
   logic [NR_BITS-1:0]        out_rd_q;
   logic                      out_wb_q;
   logic                      out_eop_q;
   logic [NUM_THREADS*32-1:0] out_data_q;

   logic [IDX_W-1:0] grant_idx;
   logic             grant_vld;
   logic             can_accept;
   logic             xfer;
   int unsigned      rr_idx;

   logic [UUID_BITS-1:0]      sel_uuid;
   logic [NW_BITS-1:0]        sel_wid;
   logic [NUM_THREADS-1:0]    sel_tmask;
   logic [31:0]               sel_pc;
   logic [NR_BITS-1:0]        sel_rd;
   logic                      sel_wb;
   logic                      sel_eop;
   logic                      sel_valid;
   logic [NUM_THREADS*32-1:0] sel_data;

   // Slot can take a new entry when empty or being drained this cycle.
   assign can_accept = ~out_valid_q | out_ready_i;

   // Grant: locked source if a multi-beat commit is open, else first valid at/after ptr.
   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      rr_idx    = 0;
      if (lock_q) begin
         grant_idx = lock_idx_q;
         grant_vld = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            rr_idx = (32'(ptr_q) + i) % NUM_REQS;
            if (!grant_vld && in_valid_i[rr_idx]) begin
               grant_vld = 1'b1;
               grant_idx = IDX_W'(rr_idx);
            end
         end
      end
   end

   // Mux the granted source's fields and drive the one-hot ready.
   always_comb begin
      sel_uuid   = '0;
      sel_wid    = '0;
      sel_tmask  = '0;
      sel_pc     = '0;
      sel_rd     = '0;
      sel_wb     = 1'b0;
      sel_eop    = 1'b0;
      sel_valid  = 1'b0;
      sel_data   = '0;
      in_ready_o = '0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         if (grant_idx == IDX_W'(k)) begin
            sel_uuid  = in_uuid_i[k*UUID_BITS +: UUID_BITS];
            sel_wid   = in_wid_i[k*NW_BITS +: NW_BITS];
            sel_tmask = in_tmask_i[k*NUM_THREADS +: NUM_THREADS];
            sel_pc    = in_PC_i[k*32 +: 32];
            sel_rd    = in_rd_i[k*NR_BITS +: NR_BITS];
            sel_wb    = in_wb_i[k];
            sel_eop   = in_eop_i[k];
            sel_valid = in_valid_i[k];
            sel_data  = in_data_i[k*NUM_THREADS*32 +: NUM_THREADS*32];
            in_ready_o[k] = grant_vld & can_accept & ~reset_i;
         end
      end
   end

   assign xfer = grant_vld & sel_valid & can_accept & ~reset_i;

   // Control state: slot occupancy, round-robin pointer and multi-beat lock.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         if (sel_eop) begin
            ptr_q  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            lock_q <= 1'b0;
         end else begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant_idx;
         end
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   // Payload register; contents are don't-care while the slot is empty.
   always_ff @(posedge clk_i) begin
      if (xfer) begin
         out_uuid_q  <= sel_uuid;
         out_wid_q   <= sel_wid;
         out_tmask_q <= sel_tmask;
         out_pc_q    <= sel_pc;
         out_rd_q    <= sel_rd;
         out_wb_q    <= sel_wb;
         out_eop_q   <= sel_eop;
         out_data_q  <= sel_data;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_uuid_o  = out_uuid_q;
   assign out_wid_o   = out_wid_q;
   assign out_tmask_o = out_tmask_q;
   assign out_PC_o    = out_pc_q;
   assign out_rd_o    = out_rd_q;
   assign out_wb_o    = out_wb_q;
   assign out_eop_o   = out_eop_q;
   assign out_data_o  = out_data_q;

`ifdef COMMIT_PERF_COUNTERS_EN
   logic [63:0] perf_q, perf_d;

   assign perf_d = (out_valid_q && out_ready_i && out_eop_q) ? perf_q + 64'd1 : perf_q;

   // Count retired instructions (eop beats leaving the slot).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_commits_o = perf_q;
`else
   assign perf_commits_o = '0;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed self-checking bench for commit_arbiter (default parameters).
module tb_commit_arbiter;

   logic           clk = 1'b0;
   logic           reset;
   logic [3:0]     in_valid;
   logic [3:0]     in_ready;
   logic [175:0]   in_uuid;
   logic [7:0]     in_wid;
   logic [15:0]    in_tmask;
   logic [127:0]   in_pc;
   logic [23:0]    in_rd;
   logic [3:0]     in_wb;
   logic [3:0]     in_eop;
   logic [511:0]   in_data;
   logic           out_valid;
   logic [43:0]    out_uuid;
   logic [1:0]     out_wid;
   logic [3:0]     out_tmask;
   logic [31:0]    out_pc;
   logic [5:0]     out_rd;
   logic           out_wb;
   logic           out_eop;
   logic [127:0]   out_data;
   logic           out_ready;
   logic [63:0]    perf_commits;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   commit_arbiter dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_uuid_i     (in_uuid),
      .in_wid_i      (in_wid),
      .in_tmask_i    (in_tmask),
      .in_PC_i       (in_pc),
      .in_rd_i       (in_rd),
      .in_wb_i       (in_wb),
      .in_eop_i      (in_eop),
      .in_data_i     (in_data),
      .out_valid_o   (out_valid),
      .out_uuid_o    (out_uuid),
      .out_wid_o     (out_wid),
      .out_tmask_o   (out_tmask),
      .out_PC_o      (out_pc),
      .out_rd_o      (out_rd),
      .out_wb_o      (out_wb),
      .out_eop_o     (out_eop),
      .out_data_o    (out_data),
      .out_ready_i   (out_ready),
      .perf_commits_o(perf_commits)
   );

   function automatic logic [127:0] lanes(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Source k fields: wid=k, tmask=k+1, PC=0x1000+4k, rd=k+8.
   task automatic set_src(input int k, input logic v, input logic eop, input logic wb,
                          input logic [43:0] uuid, input logic [31:0] base);
      in_valid[k]            = v;
      in_eop[k]              = eop;
      in_wb[k]               = wb;
      in_uuid[k*44 +: 44]    = uuid;
      in_wid[k*2 +: 2]       = 2'(k);
      in_tmask[k*4 +: 4]     = 4'(k + 1);
      in_pc[k*32 +: 32]      = 32'h1000 + 32'(4 * k);
      in_rd[k*6 +: 6]        = 6'(k + 8);
      in_data[k*128 +: 128]  = lanes(base);
   endtask

   task automatic clear_all();
      in_valid = '0; in_eop = '0; in_wb = '0; in_uuid = '0; in_wid = '0;
      in_tmask = '0; in_pc = '0; in_rd = '0; in_data = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      clear_all();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) set_src(k, 1'b1, 1'b1, 1'b1, 44'(k), 32'h0);
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      end
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (perf_commits !== 64'd0) begin
         n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_commits);
      end
      reset = 1'b0;
      clear_all();
      #1;
   endtask

   task automatic test_simul();
      apply_reset();
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h100, 32'hA0);
      set_src(2, 1'b1, 1'b1, 1'b1, 44'h102, 32'hA2);
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL simul_grant0: got %b expected 0001", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h100) begin
         n_fail++; $display("FAIL simul_out0: got v=%b uuid=%h expected v=1 uuid=100",
                            out_valid, out_uuid);
      end
      in_valid[0] = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) begin
         n_fail++; $display("FAIL simul_grant2: got %b expected 0100", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h102) begin
         n_fail++; $display("FAIL simul_out2: got v=%b uuid=%h expected v=1 uuid=102",
                            out_valid, out_uuid);
      end
      clear_all();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL simul_drain: got %b expected 0", out_valid);
      end
      // Pointer should now sit at 3: source 3 beats source 0.
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h200, 32'hB0);
      set_src(3, 1'b1, 1'b1, 1'b1, 44'h203, 32'hB3);
      #1;
      n_checks++;
      if (in_ready !== 4'b1000) begin
         n_fail++; $display("FAIL simul_ptr3: got %b expected 1000", in_ready);
      end
      tick();
      n_checks++;
      if (out_uuid !== 44'h203) begin
         n_fail++; $display("FAIL simul_out3: got %h expected 203", out_uuid);
      end
      clear_all();
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      apply_reset();
      for (int k = 0; k < 4; k++) set_src(k, 1'b1, 1'b1, 1'b1, 44'h300 + 44'(k), 32'h0);
      #1;
      for (int i = 0; i < 8; i++) begin
         exp_rdy = 4'b0001 << (i % 4);
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, in_ready, exp_rdy);
         end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_uuid !== 44'h300 + 44'(i % 4)) begin
            n_fail++; $display("FAIL rr_out[%0d]: got v=%b uuid=%h expected v=1 uuid=%h",
                               i, out_valid, out_uuid, 44'h300 + 44'(i % 4));
         end
      end
      clear_all();
      tick();
   endtask

   task automatic test_lock();
      apply_reset();
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h50, 32'h0);
      tick();
      n_checks++;
      if (out_uuid !== 44'h50) begin
         n_fail++; $display("FAIL lock_pre: got %h expected 50", out_uuid);
      end
      // Pointer is 1; source 1 opens a multi-beat commit.
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h51, 32'h0);
      set_src(1, 1'b1, 1'b0, 1'b1, 44'h61, 32'h0);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL lock_beat1_rdy: got %b expected 0010", in_ready);
      end
      tick();
      n_checks++;
      if (out_uuid !== 44'h61) begin
         n_fail++; $display("FAIL lock_beat1: got %h expected 61", out_uuid);
      end
      in_valid[1] = 1'b0;
      #1;
      n_checks++;
      if (in_ready[0] !== 1'b0) begin
         n_fail++; $display("FAIL lock_gap_rdy0: got %b expected 0", in_ready[0]);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL lock_gap_out: got %b expected 0", out_valid);
      end
      set_src(1, 1'b1, 1'b0, 1'b1, 44'h62, 32'h0);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL lock_beat2_rdy: got %b expected 0010", in_ready);
      end
      tick();
      n_checks++;
      if (out_uuid !== 44'h62) begin
         n_fail++; $display("FAIL lock_beat2: got %h expected 62", out_uuid);
      end
      set_src(1, 1'b1, 1'b1, 1'b1, 44'h63, 32'h0);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL lock_beat3_rdy: got %b expected 0010", in_ready);
      end
      tick();
      n_checks++;
      if (out_uuid !== 44'h63) begin
         n_fail++; $display("FAIL lock_beat3: got %h expected 63", out_uuid);
      end
      in_valid[1] = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL lock_release_rdy: got %b expected 0001", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h51) begin
         n_fail++; $display("FAIL lock_release_out: got v=%b uuid=%h expected v=1 uuid=51",
                            out_valid, out_uuid);
      end
      clear_all();
      tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready = 1'b0;
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h70, 32'hDEADBEEF);
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL bp_first_rdy: got %b expected 0001", in_ready);
      end
      tick();
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h71, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_uuid !== 44'h70 || out_data !== lanes(32'hDEADBEEF)) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b uuid=%h data=%h expected v=1 uuid=70 data=%h",
                               i, out_valid, out_uuid, out_data, lanes(32'hDEADBEEF));
         end
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_hold_rdy[%0d]: got %b expected 0000", i, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL bp_release_rdy: got %b expected 0001", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h71 || out_data !== lanes(32'h12345678)) begin
         n_fail++; $display("FAIL bp_refill: got v=%b uuid=%h data=%h expected v=1 uuid=71",
                            out_valid, out_uuid, out_data);
      end
      clear_all();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_fields();
      apply_reset();
      set_src(3, 1'b1, 1'b1, 1'b0, 44'hABC_DEF0_1234, 32'hCAFE0000);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'hABC_DEF0_1234 || out_wid !== 2'd3 ||
          out_tmask !== 4'd4 || out_pc !== 32'h100C || out_rd !== 6'd11 ||
          out_wb !== 1'b0 || out_eop !== 1'b1 || out_data !== lanes(32'hCAFE0000)) begin
         n_fail++;
         $display("FAIL fields_wb0: got v=%b uuid=%h wid=%0d tmask=%h pc=%h rd=%0d wb=%b eop=%b data=%h",
                  out_valid, out_uuid, out_wid, out_tmask, out_pc, out_rd, out_wb, out_eop,
                  out_data);
      end
      clear_all();
      tick();
   endtask

   task automatic test_mid_reset();
      apply_reset();
      out_ready = 1'b0;
      set_src(1, 1'b1, 1'b0, 1'b1, 44'h81, 32'h0);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h81) begin
         n_fail++; $display("FAIL mrst_setup: got v=%b uuid=%h expected v=1 uuid=81",
                            out_valid, out_uuid);
      end
      reset = 1'b1;
      set_src(0, 1'b1, 1'b1, 1'b1, 44'h90, 32'h0);
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL mrst_rdy: got %b expected 0000", in_ready);
      end
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL mrst_grant0: got %b expected 0001", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_uuid !== 44'h90) begin
         n_fail++; $display("FAIL mrst_out0: got v=%b uuid=%h expected v=1 uuid=90",
                            out_valid, out_uuid);
      end
      clear_all();
      tick();
   endtask

   task automatic test_perf();
      logic [13:0] eops;
      logic [63:0] exp_perf;
      eops = 14'b11011101101101;
`ifdef COMMIT_PERF_COUNTERS_EN
      exp_perf = 64'd10;
`else
      exp_perf = 64'd0;
`endif
      apply_reset();
      for (int i = 0; i < 14; i++) begin
         set_src(0, 1'b1, eops[i], 1'b1, 44'h400 + 44'(i), 32'h0);
         tick();
      end
      clear_all();
      tick();
      n_checks++;
      if (perf_commits !== exp_perf) begin
         n_fail++; $display("FAIL perf_count: got %0d expected %0d", perf_commits, exp_perf);
      end
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b1;
      clear_all();
      test_reset();
      test_simul();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_fields();
      test_mid_reset();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
